// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating-priority arbiter sharing one memory port between icache and dcache
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, RESP_I, RESP_D} state_t;
  state_t state, state_n;
  logic last_grant, last_grant_n;
  logic grant_d;
  // state and grant-history registers; last_grant 0 = icache, 1 = dcache
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
    end
  end
  assign grant_d = dc_req_valid && (!ic_req_valid || !last_grant);
  // arbitration in IDLE, then hold the owner until its request and response complete
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    case (state)
      IDLE: if (ic_req_valid || dc_req_valid) begin
        state_n      = grant_d ? REQ_D : REQ_I;
        last_grant_n = grant_d;
      end
      REQ_I: if (mem_req_ready) state_n = RESP_I;
      REQ_D: if (mem_req_ready) state_n = dc_req_rw ? IDLE : RESP_D;
      RESP_I, RESP_D: if (mem_resp_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // request/response routing is purely a function of the owning state
  always_comb begin
    mem_req_valid = state == REQ_I || state == REQ_D;
    mem_req_rw    = state == REQ_D && dc_req_rw;
    mem_req_addr  = state == REQ_D ? dc_req_addr : ic_req_addr;
    mem_req_wdata = state == REQ_D ? dc_req_wdata : '0;
    ic_req_ready  = state == REQ_I && mem_req_ready;
    dc_req_ready  = state == REQ_D && mem_req_ready;
    ic_resp_valid = state == RESP_I && mem_resp_valid;
    dc_resp_valid = state == RESP_D && mem_resp_valid;
    ic_resp_data  = mem_resp_data;
    dc_resp_data  = mem_resp_data;
    busy          = state != IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven per-cycle vectors plus a hand-written handshake sequence
module tb_mem_arbiter;
  localparam logic [27:0]  A1 = 28'h0000010, A2 = 28'h0000020, A3 = 28'h0000030;
  localparam logic [27:0]  A4 = 28'h0000040, A5 = 28'h0000050;
  localparam logic [127:0] D1 = {4{32'hDEADBEEF}};
  localparam logic [127:0] W  = {4{32'h12345678}};
  localparam logic [127:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D3 = ~D1;
  logic clk = 1'b0, reset;
  logic ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [27:0] ic_req_addr;
  logic [127:0] ic_resp_data;
  logic dc_req_valid, dc_req_rw, dc_req_ready, dc_resp_valid;
  logic [27:0] dc_req_addr;
  logic [127:0] dc_req_wdata, dc_resp_data;
  logic mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid, busy;
  logic [27:0] mem_req_addr;
  logic [127:0] mem_req_wdata, mem_resp_data;
  int tests = 0, fails = 0;
  typedef struct {
    string n;
    logic rst, iv, dv, drw, mr, mv;
    logic [27:0] ia, da;
    logic [127:0] wd, rd;
    logic [6:0] e;
    logic [27:0] ea;
    logic [127:0] ew, ed;
  } vec_t;
  vec_t q[$];
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end
  function automatic vec_t mk(string n, logic rst, iv, dv, drw, mr, mv, logic [27:0] ia, da,
                              logic [127:0] wd, rd, logic [6:0] e, logic [27:0] ea,
                              logic [127:0] ew, ed);
    vec_t v;
    v.n = n; v.rst = rst; v.iv = iv; v.dv = dv; v.drw = drw; v.mr = mr; v.mv = mv;
    v.ia = ia; v.da = da; v.wd = wd; v.rd = rd; v.e = e; v.ea = ea; v.ew = ew; v.ed = ed;
    return v;
  endfunction
  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", n, act, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    ic_req_valid = 0; ic_req_addr = 0; dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = 0;
    dc_req_wdata = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    // flags: {busy, mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid}
    q.push_back(mk("rst_idle", 0,0,0,0,0,0, 0,0, 0,0, 7'b0000000, 0,0,0));
    q.push_back(mk("i_arb",    0,1,0,0,0,0, A1,0, 0,0, 7'b0000000, 0,0,0));
    q.push_back(mk("i_req",    0,1,0,0,1,0, A1,0, 0,0, 7'b1101000, A1,0,0));
    q.push_back(mk("i_wait",   0,0,0,0,0,0, A1,0, 0,0, 7'b1000000, 0,0,0));
    q.push_back(mk("i_resp",   0,0,0,0,0,1, A1,0, 0,D1, 7'b1000010, 0,0,D1));
    q.push_back(mk("i_idle",   0,0,0,0,0,0, 0,0, 0,0, 7'b0000000, 0,0,0));
    q.push_back(mk("rst2",     1,0,0,0,0,0, 0,0, 0,0, 7'b0000000, 0,0,0));
    for (int k = 0; k < 6; k++) begin
      logic d;
      logic [127:0] rdk;
      d = k % 2 == 0;
      rdk = D1 ^ 128'(k);
      q.push_back(mk("arb_idle", 0,1,1,0,1,1, A1,A2, 0,rdk, 7'b0000000, 0,0,0));
      q.push_back(mk(d ? "arb_req_d" : "arb_req_i", 0,1,1,0,1,1, A1,A2, 0,rdk,
                     d ? 7'b1100100 : 7'b1101000, d ? A2 : A1, 0,0));
      q.push_back(mk(d ? "arb_resp_d" : "arb_resp_i", 0,1,1,0,1,1, A1,A2, 0,rdk,
                     d ? 7'b1000001 : 7'b1000010, 0,0,rdk));
    end
    q.push_back(mk("w_arb", 0,0,1,1,0,0, 0,A3, W,0, 7'b0000000, 0,0,0));
    for (int j = 0; j < 4; j++)
      q.push_back(mk("w_hold", 0,0,1,1,0,j == 1, 0,A3, W,D1, 7'b1110000, A3,W,0));
    q.push_back(mk("w_acc",   0,0,1,1,1,0, 0,A3, W,0, 7'b1110100, A3,W,0));
    q.push_back(mk("w_done",  0,0,0,0,0,1, 0,0, 0,D1, 7'b0000000, 0,0,0));
    q.push_back(mk("x_arb",   0,0,1,0,0,0, 0,A2, 0,0, 7'b0000000, 0,0,0));
    q.push_back(mk("x_hold",  0,1,1,0,0,0, A1,A2, 0,0, 7'b1100000, A2,0,0));
    q.push_back(mk("x_hold",  0,1,1,0,0,0, A1,A2, 0,0, 7'b1100000, A2,0,0));
    q.push_back(mk("x_acc",   0,1,1,0,1,0, A1,A2, 0,0, 7'b1100100, A2,0,0));
    q.push_back(mk("x_resp",  0,1,0,0,0,1, A1,0, 0,D2, 7'b1000001, 0,0,D2));
    q.push_back(mk("x_arb_i", 0,1,0,0,0,0, A1,0, 0,0, 7'b0000000, 0,0,0));
    q.push_back(mk("x_req_i", 0,1,0,1,1,0, A1,A3, W,0, 7'b1101000, A1,0,0));
    q.push_back(mk("r_rst",   1,0,0,0,0,0, 0,0, 0,0, 7'b1000000, 0,0,0));
    q.push_back(mk("r_drop",  0,0,0,0,0,1, 0,0, 0,D1, 7'b0000000, 0,0,0));
    q.push_back(mk("r_arb",   0,1,0,0,0,0, A4,0, 0,0, 7'b0000000, 0,0,0));
    q.push_back(mk("r_req",   0,1,0,0,1,0, A4,0, 0,0, 7'b1101000, A4,0,0));
    q.push_back(mk("r_resp",  0,0,0,0,0,1, A4,0, 0,D3, 7'b1000010, 0,0,D3));
    q.push_back(mk("r_idle",  0,0,0,0,0,0, 0,0, 0,0, 7'b0000000, 0,0,0));
    repeat (2) @(posedge clk);
    foreach (q[i]) begin
      @(negedge clk);
      reset = q[i].rst; ic_req_valid = q[i].iv; ic_req_addr = q[i].ia;
      dc_req_valid = q[i].dv; dc_req_rw = q[i].drw; dc_req_addr = q[i].da; dc_req_wdata = q[i].wd;
      mem_req_ready = q[i].mr; mem_resp_valid = q[i].mv; mem_resp_data = q[i].rd;
      #1;
      chk($sformatf("%s[%0d].flags", q[i].n, i),
          {busy, mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid},
          q[i].e);
      if (q[i].e[5]) begin
        chk($sformatf("%s[%0d].addr", q[i].n, i), mem_req_addr, q[i].ea);
        chk($sformatf("%s[%0d].wdata", q[i].n, i), mem_req_wdata, q[i].ew);
      end
      if (q[i].e[1]) chk($sformatf("%s[%0d].ic_data", q[i].n, i), ic_resp_data, q[i].ed);
      if (q[i].e[0]) chk($sformatf("%s[%0d].dc_data", q[i].n, i), dc_resp_data, q[i].ed);
    end
    @(negedge clk);
    reset = 0; ic_req_valid = 1; ic_req_addr = A5; dc_req_valid = 0; dc_req_rw = 0;
    mem_req_ready = 0; mem_resp_valid = 0;
    #1;
    begin
      int n;
      n = 0;
      while (!mem_req_valid && n < 8) begin
        @(negedge clk); #1;
        n++;
      end
      chk("h_grant_latency", n, 1);
    end
    @(negedge clk); #1;
    chk("h_hold_ready", ic_req_ready, 0);
    chk("h_hold_addr", mem_req_addr, A5);
    @(negedge clk); mem_req_ready = 1; #1;
    chk("h_accept", {ic_req_ready, dc_req_ready}, 2'b10);
    @(negedge clk); ic_req_valid = 0; mem_req_ready = 0; #1;
    chk("h_pulse", {ic_req_ready, mem_req_valid, busy}, 3'b001);
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = D2; #1;
    chk("h_resp", {ic_resp_valid, dc_resp_valid}, 2'b10);
    chk("h_rdata", ic_resp_data, D2);
    @(negedge clk); mem_resp_valid = 0; #1;
    chk("h_end", {ic_resp_valid, busy}, 2'b00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing-memory request/response port between the instruction cache (read-only) and the data cache (read/write) of the Riscv151 pipeline.
- Sits between both cache miss/refill engines and the memory interface.
- At most one memory transaction is outstanding at a time.
- Alternating-priority arbitration; responses are routed back to the requester that owns the transaction.

Parameters:
ADDR_W, 28, line address width (byte address bits [31:4])
DATA_W, 128, cache line / memory beat width in bits

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ic_req_valid  input  1  icache read request pending; held until ic_req_ready
ic_req_addr  input  ADDR_W  icache line address
ic_req_ready  output  1  single-cycle pulse: icache request accepted by memory
ic_resp_valid  output  1  single-cycle pulse: ic_resp_data valid
ic_resp_data  output  DATA_W  read data for icache
dc_req_valid  input  1  dcache request pending; held until dc_req_ready
dc_req_rw  input  1  1 = write, 0 = read
dc_req_addr  input  ADDR_W  dcache line address
dc_req_wdata  input  DATA_W  dcache write data
dc_req_ready  output  1  single-cycle pulse: dcache request accepted
dc_resp_valid  output  1  single-cycle pulse: dc_resp_data valid (reads only)
dc_resp_data  output  DATA_W  read data for dcache
mem_req_valid  output  1  request to memory
mem_req_rw  output  1  1 = write
mem_req_addr  output  ADDR_W  memory address
mem_req_wdata  output  DATA_W  memory write data
mem_req_ready  input  1  memory accepts request this cycle
mem_resp_valid  input  1  memory read data valid this cycle
mem_resp_data  input  DATA_W  memory read data
busy  output  1  state != IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-high on `reset`.
- FSM states: IDLE, REQ_I, REQ_D, RESP_I, RESP_D.
- Register last_grant (0 = I, 1 = D). Reset value is I, so D wins the first tie.
- Reset behaviour:
  - state <= IDLE, last_grant <= I.
  - All valid/ready outputs are 0 in the cycle after reset is sampled.
  - busy = 0.
  - A transaction in flight when reset is sampled is dropped; no response is forwarded afterwards.
- IDLE transitions:
  - Only ic_req_valid → REQ_I, last_grant <= I.
  - Only dc_req_valid → REQ_D, last_grant <= D.
  - Both valid → grant the side not equal to last_grant.
  - Neither valid → stay in IDLE.
  - No memory request is issued in IDLE; there is 1 cycle of arbitration latency.
- REQ_x:
  - mem_req_valid = 1. mem_req_addr/rw/wdata come from owner x; for the icache, rw = 0 and wdata = 0.
  - Outputs are driven combinationally from state, so they are stable until accepted.
  - On mem_req_ready: x_req_ready = 1 for that cycle only. Next state is RESP_x for a read, IDLE for a write (dcache only).
  - Without mem_req_ready: hold in REQ_x. The owner must keep its inputs stable.
  - The other requester's valid is ignored and it gets no ready.
- RESP_x:
  - mem_req_valid = 0.
  - On mem_resp_valid: x_resp_valid = 1 and x_resp_data = mem_resp_data (combinational pass-through, same cycle), then → IDLE.
  - The non-owner's resp_valid stays 0.
- mem_resp_valid outside RESP_x is ignored, with no output effect.
- ic_resp_data and dc_resp_data may mirror mem_resp_data continuously; they are qualified only by their resp_valid.
- Back-to-back operation:
  - A request accepted in the same cycle IDLE is re-entered is arbitrated on the following cycle.
  - Minimum read turnaround is 3 cycles: IDLE, REQ, RESP with a same-cycle ready/response.
- Invariants:
  - mem_req_valid is high only in REQ_I/REQ_D.
  - Each ready/resp pulse is exactly 1 cycle.
  - ic_req_ready and dc_req_ready are never high together.
- Starvation-free: with both requesters continuously valid, grants alternate I/D.

Test Plan:
- Reset, then idle: ic_req_valid = 1, addr 0x0000010, memory ready immediately, response 2 cycles later with data 0xDEADBEEF… → mem_req_valid in cycle 2 with addr 0x0000010, rw = 0; ic_req_ready pulses 1 cycle; ic_resp_valid with matching data; dc_resp_valid stays 0.
- Both ic and dc valid from reset with dc read 0x0000020 → dc granted first; after dc_resp_valid, icache granted next; with both held continuously for 6 transactions → grant order D,I,D,I,D,I.
- dc write, rw = 1, addr 0x0000030, wdata 0x1234…, with mem_req_ready delayed 4 cycles:
  - mem_req_* stays stable for all 4 cycles.
  - dc_req_ready pulses in the acceptance cycle.
  - FSM returns to IDLE with no dc_resp_valid.
- Spurious mem_resp_valid in IDLE and REQ_D → no ic/dc resp_valid asserted; the state sequence is unchanged.
- Assert reset while in RESP_I, then pulse mem_resp_valid → ic_resp_valid stays 0; state is IDLE and busy = 0 after reset; a new request is serviced normally afterward.
- icache request arriving while dcache owns REQ_D with no mem_req_ready → ic_req_ready stays 0 until the dcache transaction completes and IDLE re-arbitrates to I.
